// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button debouncer.
package button_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_REL_CHK   = 2'd3
    } btn_state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: FSM, stability and hold counters, registered outputs.
// Input i_s is already synchronised and normalised (1 = pressed).
module debounce_channel
    import button_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_s,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int SW = clog2(STABLE_TICKS + 1);
    localparam int HW = clog2(LONG_TICKS + 1);

    localparam logic [SW-1:0] STAB_ONE  = SW'(1);
    localparam logic [SW-1:0] STAB_DONE = SW'(STABLE_TICKS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_TICKS);

    btn_state_t    r_state;
    btn_state_t    w_state_next;
    logic [SW-1:0] r_stab_cnt;
    logic [SW-1:0] w_stab_next;
    logic [SW-1:0] w_stab_inc;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_next;
    logic [HW-1:0] w_hold_inc;
    logic          w_hold_sat;
    logic          w_hold_hits;
    logic          r_level;
    logic          w_level_next;
    logic          r_press;
    logic          w_press_next;
    logic          r_release;
    logic          w_release_next;
    logic          r_long;
    logic          w_long_next;

    // The stability count never sits at STABLE_TICKS, so a plain increment is safe.
    assign w_stab_inc  = r_stab_cnt + STAB_ONE;
    // Hold count saturates at LONG_TICKS so the long pulse fires exactly once per press.
    assign w_hold_sat  = (r_hold_cnt == HOLD_LONG);
    assign w_hold_inc  = w_hold_sat ? r_hold_cnt : (r_hold_cnt + HOLD_ONE);
    assign w_hold_hits = !w_hold_sat && ((r_hold_cnt + HOLD_ONE) == HOLD_LONG);

    // Next state, counters and output pulses; everything holds unless a tick arrives.
    always_comb begin
        w_state_next   = r_state;
        w_stab_next    = r_stab_cnt;
        w_hold_next    = r_hold_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_long_next    = 1'b0;
        if (i_tick) begin
            case (r_state)
                ST_RELEASED: begin
                    if (i_s) begin
                        w_state_next = ST_PRESS_CHK;
                        w_stab_next  = STAB_ONE;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!i_s) begin
                        w_state_next = ST_RELEASED;
                        w_stab_next  = '0;
                    end else if (w_stab_inc == STAB_DONE) begin
                        w_state_next = ST_PRESSED;
                        w_stab_next  = '0;
                        w_hold_next  = '0;
                        w_press_next = 1'b1;
                    end else begin
                        w_stab_next  = w_stab_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!i_s) begin
                        w_state_next = ST_REL_CHK;
                        w_stab_next  = STAB_ONE;
                    end else begin
                        w_hold_next  = w_hold_inc;
                        w_long_next  = w_hold_hits;
                    end
                end
                ST_REL_CHK: begin
                    // Long timing keeps running through a release check, bounce or not.
                    w_hold_next = w_hold_inc;
                    w_long_next = w_hold_hits;
                    if (i_s) begin
                        w_state_next = ST_PRESSED;
                        w_stab_next  = '0;
                    end else if (w_stab_inc == STAB_DONE) begin
                        w_state_next   = ST_RELEASED;
                        w_stab_next    = '0;
                        w_hold_next    = '0;
                        w_release_next = 1'b1;
                    end else begin
                        w_stab_next = w_stab_inc;
                    end
                end
                default: begin
                    w_state_next = ST_RELEASED;
                    w_stab_next  = '0;
                    w_hold_next  = '0;
                end
            endcase
        end
        w_level_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_REL_CHK);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RELEASED;
            r_stab_cnt <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_stab_cnt <= w_stab_next;
            r_hold_cnt <= w_hold_next;
            r_level    <= w_level_next;
            r_press    <= w_press_next;
            r_release  <= w_release_next;
            r_long     <= w_long_next;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: pad synchroniser plus one
// debounce channel per button, all paced by the shared prescaler tick.
module button_debounce
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS   = 4,
    parameter int STABLE_TICKS  = 3,
    parameter int LONG_TICKS    = 20,
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_long
);

    // Pad value of an untouched button; the synchroniser resets to it so
    // no phantom press appears when reset is released.
    localparam logic [NUM_BUTTONS-1:0] PAD_RELEASED = {NUM_BUTTONS{ACTIVE_LOW_IN}};

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] w_pressed;

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= PAD_RELEASED;
            r_sync2 <= PAD_RELEASED;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity so that 1 always means pressed.
    assign w_pressed = r_sync2 ^ PAD_RELEASED;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (tick),
            .i_s       (w_pressed[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (btn_press[gi]),
            .o_release (btn_release[gi]),
            .o_long    (btn_long[gi])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce with a scoreboard fed
// by a behavioural model (run-length of disagreeing tick samples).
module tb_button_debounce;

    localparam int NB = 2;
    localparam int ST = 3;
    localparam int LT = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [NB-1:0] btn_raw = '1;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    always #5 clk = ~clk;

    button_debounce #(
        .NUM_BUTTONS   (NB),
        .STABLE_TICKS  (ST),
        .LONG_TICKS    (LT),
        .ACTIVE_LOW_IN (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    typedef struct {
        int            cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
    } ev_t;

    ev_t exp_q[$];
    ev_t m_ev;
    ev_t mon_e;
    int  checks = 0;
    int  fails = 0;
    int  cyc = 0;

    // Model state
    logic [NB-1:0] m_p1;
    logic [NB-1:0] m_p2;
    logic [NB-1:0] m_lvl;
    int            m_run[NB];
    int            m_held[NB];
    logic          m_s;

    // DUT pulse counters for directed scenarios
    int n_press[NB];
    int n_rel[NB];
    int n_long[NB];
    int n_both;

    // Reference model: a change is accepted after ST consecutive tick
    // samples disagree with the accepted level; long fires when the number
    // of counted held ticks since acceptance equals LT.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_p1  = '1;
                m_p2  = '1;
                m_lvl = '0;
                for (int j = 0; j < NB; j++) begin
                    m_run[j]  = 0;
                    m_held[j] = 0;
                end
                exp_q.delete();
            end else begin
                cyc++;
                m_ev.cyc   = cyc;
                m_ev.press = '0;
                m_ev.rel   = '0;
                m_ev.lng   = '0;
                if (tick) begin
                    for (int j = 0; j < NB; j++) begin
                        m_s = !m_p2[j];
                        if (m_lvl[j]) begin
                            // the first released sample of a release check does not count
                            if (!(m_s == 1'b0 && m_run[j] == 0)) begin
                                m_held[j]++;
                                if (m_held[j] == LT) m_ev.lng[j] = 1'b1;
                            end
                        end
                        if (m_s != m_lvl[j]) begin
                            m_run[j]++;
                            if (m_run[j] == ST) begin
                                m_lvl[j]  = m_s;
                                m_run[j]  = 0;
                                m_held[j] = 0;
                                if (m_s) m_ev.press[j] = 1'b1;
                                else     m_ev.rel[j]   = 1'b1;
                            end
                        end else begin
                            m_run[j] = 0;
                        end
                    end
                end
                m_p2 = m_p1;
                m_p1 = btn_raw;
                if (|{m_ev.press, m_ev.rel, m_ev.lng}) exp_q.push_back(m_ev);
            end
        end
    end

    // Monitor: level every cycle, pulses against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (btn_level !== m_lvl) begin
                    fails++;
                    $display("FAIL level cyc=%0d got=%b expected=%b", cyc, btn_level, m_lvl);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    fails++;
                    $display("FAIL missed_event cyc=%0d got=none expected press=%b rel=%b long=%b",
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lng);
                end
                if (|{btn_press, btn_release, btn_long}) begin
                    checks++;
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                        mon_e = exp_q.pop_front();
                        if (btn_press !== mon_e.press || btn_release !== mon_e.rel ||
                            btn_long !== mon_e.lng) begin
                            fails++;
                            $display("FAIL event cyc=%0d got press=%b rel=%b long=%b expected press=%b rel=%b long=%b",
                                     cyc, btn_press, btn_release, btn_long,
                                     mon_e.press, mon_e.rel, mon_e.lng);
                        end
                    end else begin
                        fails++;
                        $display("FAIL unexpected_event cyc=%0d got press=%b rel=%b long=%b expected none",
                                 cyc, btn_press, btn_release, btn_long);
                    end
                    for (int j = 0; j < NB; j++) begin
                        if (btn_press[j])   n_press[j]++;
                        if (btn_release[j]) n_rel[j]++;
                        if (btn_long[j])    n_long[j]++;
                    end
                    if (btn_press == '1) n_both++;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic clear_counts();
        for (int j = 0; j < NB; j++) begin
            n_press[j] = 0;
            n_rel[j]   = 0;
            n_long[j]  = 0;
        end
        n_both = 0;
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic t);
        @(posedge clk);
        #3;
        btn_raw = raw;
        tick    = t;
    endtask

    // One tick period: 8 clk, tick on the 5th so the synchroniser has settled.
    task automatic periods(input logic [NB-1:0] raw, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < 8; c++) step(raw, c == 4);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_level"},   int'(btn_level),   0);
        check({name, "_press"},   int'(btn_press),   0);
        check({name, "_release"}, int'(btn_release), 0);
        check({name, "_long"},    int'(btn_long),    0);
    endtask

    logic [NB-1:0] v;
    logic [NB-1:0] r;

    initial begin
        clear_counts();
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        #2;
        rst_n = 1'b1;

        // tick stuck low: raw noise must never be accepted
        for (int i = 0; i < 200; i++) step(NB'($urandom), 1'b0);
        #1;
        check_outputs_zero("tick_stuck");
        periods('1, 3);

        // Clean press on channel 0, then release
        clear_counts();
        periods(2'b10, 4);
        check("clean_press0", n_press[0], 1);
        check("clean_press1", n_press[1], 0);
        check("clean_level", int'(btn_level), 1);
        periods(2'b11, 4);
        check("clean_release0", n_rel[0], 1);
        check("clean_long0", n_long[0], 0);
        check("clean_ch1_release", n_rel[1], 0);

        // Bounce shorter than the stability window
        clear_counts();
        periods(2'b10, 2);
        periods(2'b11, 1);
        periods(2'b10, 2);
        check("bounce_press0", n_press[0], 0);
        check("bounce_level", int'(btn_level), 0);
        periods(2'b11, 4);

        // Long press then release
        clear_counts();
        periods(2'b10, 10);
        check("long_press0", n_press[0], 1);
        check("long_long0", n_long[0], 1);
        periods(2'b11, 4);
        check("long_release0", n_rel[0], 1);
        check("long_long0_once", n_long[0], 1);
        check("long_level_after", int'(btn_level), 0);

        // Simultaneous press on both channels
        clear_counts();
        periods(2'b00, 4);
        check("simul_both", n_both, 1);
        periods(2'b11, 4);
        check("simul_rel1", n_rel[1], 1);

        // Random with glitches, regular tick
        v = '1;
        for (int p = 0; p < 150; p++) begin
            if ($urandom % 2 == 0) v = NB'($urandom);
            for (int c = 0; c < 8; c++) begin
                r = v;
                if ($urandom % 6 == 0) r = r ^ NB'($urandom);
                step(r, c == 4);
            end
        end
        // Random with irregular, sometimes back-to-back ticks
        for (int i = 0; i < 800; i++) begin
            if ($urandom % 10 == 0) v = NB'($urandom);
            step(v, ($urandom % 3) == 0);
        end
        periods('1, 5);

        // Reset in the middle of a press: no release afterwards
        clear_counts();
        periods(2'b00, 6);
        check("midreset_level_before", int'(btn_level), 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        step(2'b00, 1'b0);
        step(2'b11, 1'b0);
        @(posedge clk);
        #3;
        rst_n   = 1'b1;
        btn_raw = '1;
        periods('1, 5);
        check("midreset_rel0", n_rel[0], 0);
        check("midreset_rel1", n_rel[1], 0);
        check("midreset_level_after", int'(btn_level), 0);

        repeat (4) step('1, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
